fir_feed_controller: RTL
========================

# fir_feed_controller

Sequencer that drives the control/data side of the n-tap FIR filter: it holds a programmable coefficient table, loads it into the filter through the serial coefficient protocol, streams buffered input samples with per-sample load strobes, and ends the run with a stop strobe. It sits directly upstream of the FIR instance. It decouples an upstream valid/ready sample source from the filter's strobe-driven interface.

## Interface
- LENGTH, 20, number of taps and coefficient table entries
- DATA_WIDTH, 8, signed coefficient and sample width
- FIFO_DEPTH, 16, sample buffer entries (power of two, ≥2)
- clock  in  1  sole clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- coeffWrEn  in  1  write strobe for coefficient table
- coeffWrAddr  in  $clog2(LENGTH)  table index (0 = first coefficient sent)
- coeffWrData  in  DATA_WIDTH  signed coefficient value
- start  in  1  begin a run (pulse)
- sampleValid  in  1  upstream sample valid
- sampleIn  in  DATA_WIDTH  signed sample
- sampleLast  in  1  marks final sample of run, qualified by sampleValid
- sampleReady  out  1  sample accepted when sampleValid && sampleReady
- loadCoeff  out  1  coefficient-load request to FIR
- coeffSetFlag  out  1  high on the cycle the last coefficient is driven
- coeffIn  out  DATA_WIDTH  coefficient to FIR
- loadDataFlag  out  1  dataIn valid, FIR consumes this cycle
- dataIn  out  DATA_WIDTH  sample to FIR
- stopDataLoadFlag  out  1  end-of-run strobe to FIR
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
- All outputs registered; reset value of every output 0; reset clears table, FIFO pointers, counters, state → IDLE. Reset mid-run abandons the run immediately.
- States: IDLE, REQ, COEFF, STREAM, FLUSH, STOP, HOLD, DONE.
- IDLE: table writes accepted (coeffWrAddr ≥ LENGTH ignored); start → REQ. start while busy ignored; coeffWrEn while busy ignored.
- REQ: loadCoeff=1 for exactly one cycle → COEFF.
- COEFF: LENGTH cycles, coeffIn = table[idx], idx 0..LENGTH-1; coeffSetFlag=1 with idx LENGTH-1 → STREAM. loadDataFlag held 0.
- sampleReady = !full in REQ, COEFF, STREAM (until sampleLast accepted); 0 elsewhere. Samples after sampleLast refused.
- STREAM: each cycle FIFO non-empty → pop, loadDataFlag=1, dataIn=head; empty → loadDataFlag=0, dataIn holds. When the sampleLast entry is popped → FLUSH (macro on) or STOP.
- STOP: stopDataLoadFlag=1 one cycle → HOLD (one cycle, lets FIR pass its STOP state back to IDLE) → DONE (done=1) → IDLE.
- Simultaneous push and pop on full FIFO allowed only when pop occurs (ready computed from registered full, no pass-through).

## Timing
- start sampled at edge t: loadCoeff high cycle t+1; coeffIn=table[0] cycle t+2; table[LENGTH-1] with coeffSetFlag cycle t+LENGTH+1; earliest loadDataFlag cycle t+LENGTH+2.
- Sample accepted at edge k appears on dataIn no earlier than cycle after edge k+1.
- Back-to-back runs: next loadCoeff no earlier than 3 cycles after stopDataLoadFlag.
- Throughput: one sample per cycle while FIFO non-empty.

## Configuration
- FIR_FLUSH_EN defined: FLUSH state issues LENGTH-1 extra loadDataFlag strobes with dataIn=0 before STOP, pushing the full impulse tail out of the filter.
- Undefined: FLUSH state absent; STREAM goes straight to STOP after the last sample.

## Structure
- Package fir_feed_pkg: state enumeration, ADDR_WIDTH/PTR_WIDTH helpers, shared signed sample type.
- Sub-module fir_sample_fifo: synchronous FIFO (data + last bit), async active-low reset, full/empty flags.

## Test plan
- LENGTH=4, table {1,2,3,4}, start → loadCoeff one cycle, coeffIn 1,2,3,4 on four consecutive cycles, coeffSetFlag with 4.
- Samples 5,−3,7(last) offered continuously → loadDataFlag on three cycles with dataIn 5,−3,7, then stopDataLoadFlag, HOLD, done pulse.
- FIR_FLUSH_EN, LENGTH=4, single sample 1(last) → dataIn 1 then three zero strobes before stopDataLoadFlag.
- FIFO_DEPTH=4, source valid during COEFF → exactly 4 accepted, sampleReady=0 until first pop, no loss or reorder of 17 samples.
- Bubbly source (valid every 3rd cycle) → loadDataFlag only on cycles with data; coeffWrEn and start during STREAM have no effect.
- resetN low mid-STREAM → all outputs 0 same cycle, table reads 0 on next run, state IDLE.

Source files
------------

// File: rtl/fir_feed_pkg.sv
// ----------------------------------------------------------------------------
// Module   : fir_feed_pkg
// Brief    : Shared types and sizing helpers for the FIR feed controller.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fir_feed_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_COEFF  = 3'd2,
        ST_STREAM = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_STOP   = 3'd5,
        ST_HOLD   = 3'd6,
        ST_DONE   = 3'd7
    } feed_state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sample_fifo.sv
// ----------------------------------------------------------------------------
// Module   : fir_sample_fifo
// Brief    : Synchronous sample FIFO carrying data plus an end-of-run bit.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_sample_fifo
    import fir_feed_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int PTR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic                  pushLast,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] popData,
    output logic                  popLast,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    count
);

    localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH:0] r_mem [DEPTH];
    logic [PTR_WIDTH:0]  r_wrPtr;
    logic [PTR_WIDTH:0]  r_rdPtr;
    logic                w_doPush;
    logic                w_doPop;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign count    = r_wrPtr - r_rdPtr;
    assign full     = (count == C_DEPTH);
    assign empty    = (r_wrPtr == r_rdPtr);
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;
    assign {popLast, popData} = r_mem[r_rdPtr[PTR_WIDTH-1:0]];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_doPush) r_mem[r_wrPtr[PTR_WIDTH-1:0]] <= {pushLast, pushData};
    end

endmodule

`default_nettype wire

// File: rtl/fir_feed_controller.sv
// ----------------------------------------------------------------------------
// Module   : fir_feed_controller
// Brief    : Loads FIR coefficients, streams buffered samples, ends the run.
//            Define FIR_FLUSH_EN to append LENGTH-1 zero samples before STOP.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_feed_controller
    import fir_feed_pkg::*;
#(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int ADDR_WIDTH = addr_width(LENGTH)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  coeffWrEn,
    input  logic [ADDR_WIDTH-1:0] coeffWrAddr,
    input  logic [DATA_WIDTH-1:0] coeffWrData,
    input  logic                  start,
    input  logic                  sampleValid,
    input  logic [DATA_WIDTH-1:0] sampleIn,
    input  logic                  sampleLast,
    output logic                  sampleReady,
    output logic                  loadCoeff,
    output logic                  coeffSetFlag,
    output logic [DATA_WIDTH-1:0] coeffIn,
    output logic                  loadDataFlag,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic                  stopDataLoadFlag,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_WIDTH = ptr_width(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_IDX = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [PTR_WIDTH:0]    C_DEPTH    = (PTR_WIDTH+1)'(FIFO_DEPTH);

    feed_state_t            r_state, w_nextState;
    logic [DATA_WIDTH-1:0]  r_table [LENGTH];
    logic [ADDR_WIDTH-1:0]  r_idx, w_nIdx;
    logic                   r_seenLast, w_nSeenLast;
    logic                   r_lastAcc, w_nLastAcc;

    logic                   r_sampleReady, w_nReady;
    logic                   r_loadCoeff, w_nLoadCoeff;
    logic                   r_coeffSet, w_nCoeffSet;
    logic [DATA_WIDTH-1:0]  r_coeffIn, w_nCoeffIn;
    logic                   r_loadData, w_nLoadData;
    logic [DATA_WIDTH-1:0]  r_dataIn, w_nDataIn;
    logic                   r_stop, w_nStop;
    logic                   r_busy;
    logic                   r_done, w_nDone;

    logic                   w_push, w_pop, w_tryPop;
    logic [DATA_WIDTH-1:0]  w_fifoData;
    logic                   w_fifoLast, w_full, w_empty;
    logic [PTR_WIDTH:0]     w_count, w_countNext;
    logic                   w_addrOk;

`ifdef FIR_FLUSH_EN
    localparam logic [ADDR_WIDTH-1:0] C_FLUSH_LAST = ADDR_WIDTH'(LENGTH - 2);
    logic [ADDR_WIDTH-1:0]  r_flushCnt, w_nFlushCnt;
`endif

    assign sampleReady      = r_sampleReady;
    assign loadCoeff        = r_loadCoeff;
    assign coeffSetFlag     = r_coeffSet;
    assign coeffIn          = r_coeffIn;
    assign loadDataFlag     = r_loadData;
    assign dataIn           = r_dataIn;
    assign stopDataLoadFlag = r_stop;
    assign busy             = r_busy;
    assign done             = r_done;

    assign w_push   = sampleValid && r_sampleReady && !w_full;
    assign w_addrOk = {{(32-ADDR_WIDTH){1'b0}}, coeffWrAddr} < 32'(LENGTH);

    fir_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetN   (resetN),
        .push     (w_push),
        .pushData (sampleIn),
        .pushLast (sampleLast),
        .pop      (w_pop),
        .popData  (w_fifoData),
        .popLast  (w_fifoLast),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < LENGTH; i++) r_table[i] <= '0;
        end else if (r_state == ST_IDLE && coeffWrEn && w_addrOk) begin
            r_table[coeffWrAddr] <= coeffWrData;
        end
    end

    // Outputs are registered from the next-state decision, so every output
    // reflects the state held in r_state during the same cycle.
    always_comb begin
        w_nextState  = r_state;
        w_tryPop     = 1'b0;
        w_pop        = 1'b0;
        w_nIdx       = r_idx;
        w_nSeenLast  = r_seenLast;
        w_nLastAcc   = r_lastAcc;
        w_nLoadCoeff = 1'b0;
        w_nCoeffSet  = 1'b0;
        w_nCoeffIn   = r_coeffIn;
        w_nLoadData  = 1'b0;
        w_nDataIn    = r_dataIn;
        w_nStop      = 1'b0;
        w_nDone      = 1'b0;
`ifdef FIR_FLUSH_EN
        w_nFlushCnt  = r_flushCnt;
`endif
        if (w_push && sampleLast) w_nLastAcc = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState  = ST_REQ;
                    w_nLoadCoeff = 1'b1;
                    w_nSeenLast  = 1'b0;
                    w_nLastAcc   = 1'b0;
                end
            end
            ST_REQ: begin
                w_nextState = ST_COEFF;
                w_nIdx      = '0;
                w_nCoeffIn  = r_table[0];
                w_nCoeffSet = (C_LAST_IDX == '0);
            end
            ST_COEFF: begin
                if (r_idx == C_LAST_IDX) begin
                    w_nextState = ST_STREAM;
                    w_tryPop    = 1'b1;
                end else begin
                    w_nIdx      = r_idx + 1'b1;
                    w_nCoeffIn  = r_table[r_idx + 1'b1];
                    w_nCoeffSet = ((r_idx + 1'b1) == C_LAST_IDX);
                end
            end
            ST_STREAM: begin
                if (r_seenLast) begin
`ifdef FIR_FLUSH_EN
                    if (LENGTH > 1) begin
                        w_nextState = ST_FLUSH;
                        w_nLoadData = 1'b1;
                        w_nDataIn   = '0;
                        w_nFlushCnt = '0;
                    end else begin
                        w_nextState = ST_STOP;
                        w_nStop     = 1'b1;
                    end
`else
                    w_nextState = ST_STOP;
                    w_nStop     = 1'b1;
`endif
                end else begin
                    w_tryPop = 1'b1;
                end
            end
`ifdef FIR_FLUSH_EN
            ST_FLUSH: begin
                if (r_flushCnt == C_FLUSH_LAST) begin
                    w_nextState = ST_STOP;
                    w_nStop     = 1'b1;
                end else begin
                    w_nFlushCnt = r_flushCnt + 1'b1;
                    w_nLoadData = 1'b1;
                    w_nDataIn   = '0;
                end
            end
`endif
            ST_STOP: w_nextState = ST_HOLD;
            ST_HOLD: begin
                w_nextState = ST_DONE;
                w_nDone     = 1'b1;
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase

        if (w_tryPop && !w_empty) begin
            w_pop       = 1'b1;
            w_nLoadData = 1'b1;
            w_nDataIn   = w_fifoData;
            w_nSeenLast = w_fifoLast;
        end
    end

    // Ready is predicted from next-cycle occupancy so the FIFO never overfills
    assign w_countNext = w_count + (PTR_WIDTH+1)'(w_push) - (PTR_WIDTH+1)'(w_pop);
    assign w_nReady    = (w_nextState == ST_REQ || w_nextState == ST_COEFF ||
                          w_nextState == ST_STREAM) && !w_nLastAcc &&
                         (w_countNext != C_DEPTH);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_seenLast    <= 1'b0;
            r_lastAcc     <= 1'b0;
            r_sampleReady <= 1'b0;
            r_loadCoeff   <= 1'b0;
            r_coeffSet    <= 1'b0;
            r_coeffIn     <= '0;
            r_loadData    <= 1'b0;
            r_dataIn      <= '0;
            r_stop        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_idx         <= w_nIdx;
            r_seenLast    <= w_nSeenLast;
            r_lastAcc     <= w_nLastAcc;
            r_sampleReady <= w_nReady;
            r_loadCoeff   <= w_nLoadCoeff;
            r_coeffSet    <= w_nCoeffSet;
            r_coeffIn     <= w_nCoeffIn;
            r_loadData    <= w_nLoadData;
            r_dataIn      <= w_nDataIn;
            r_stop        <= w_nStop;
            r_busy        <= (w_nextState != ST_IDLE);
            r_done        <= w_nDone;
        end
    end

`ifdef FIR_FLUSH_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) r_flushCnt <= '0;
        else         r_flushCnt <= w_nFlushCnt;
    end
`endif

endmodule

`default_nettype wire
